// File: rtl/seg_scan_controller_if.sv
// Host-side signal bundle for seg_scan_controller.
//   field_bin  : packed 7-bit binary fields, field k at [7k+6:7k], field 0 rightmost
//   load       : single-cycle capture request for field_bin
//   blink_mask : bit k blinks field k (live level)
//   err        : live level, forces 'E' on every digit
//   enable     : live level, 0 blanks the display and releases all anodes
//   busy       : conversion in progress, load ignored
//   an         : one-hot digit select
//   seg        : segments {g,f,e,d,c,b,a}
// master = host driving the display, slave = the controller.
interface seg_scan_controller_if #(
  parameter int unsigned NUM_DIGITS = 8
);
  localparam int unsigned NUM_FIELDS = NUM_DIGITS / 2;

  logic [7*NUM_FIELDS-1:0] field_bin;
  logic                    load;
  logic [NUM_FIELDS-1:0]   blink_mask;
  logic                    err;
  logic                    enable;
  logic                    busy;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;

  modport master (
    output field_bin, load, blink_mask, err, enable,
    input  busy, an, seg
  );

  modport slave (
    input  field_bin, load, blink_mask, err, enable,
    output busy, an, seg
  );
endinterface

// File: rtl/seg_scan_controller.sv
// Multiplexed 7-segment scan controller with binary-to-decimal field conversion.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : seg_scan_controller_if slave modport (field_bin, load, blink_mask, err,
//         enable in; busy, an, seg out)
// A load captures all fields into a shadow register; one field per cycle is split
// into tens/ones digits into a pending buffer, and the whole buffer is copied to
// the displayed digits on the cycle busy falls so a partial frame is never shown.
module seg_scan_controller #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned BLINK_DIV  = 64,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  seg_scan_controller_if.slave bus
);

  localparam int unsigned NumFields = NUM_DIGITS / 2;
  localparam int unsigned IdxW      = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FldW      = (NumFields > 1) ? $clog2(NumFields) : 1;
  localparam int unsigned DivW      = $clog2(SCAN_DIV);
  localparam int unsigned FrmW      = $clog2(BLINK_DIV + 1);

  localparam logic [DivW-1:0] DivMax  = DivW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxMax  = IdxW'(NUM_DIGITS - 1);
  localparam logic [FldW-1:0] FldLast = FldW'(NumFields - 1);
  localparam logic [FrmW-1:0] FrmMax  = FrmW'(BLINK_DIV - 1);

  // Internal digit codes: 0..9 decimal, plus dash and blank.
  localparam logic [3:0] CodeDash  = 4'd10;
  localparam logic [3:0] CodeBlank = 4'd15;

  // Active-low segment patterns {g,f,e,d,c,b,a}.
  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegErr   = 7'b0000110;

  localparam logic [NUM_DIGITS-1:0] AnIdle  = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;
  localparam logic [6:0]            SegIdle = ACTIVE_LOW ? SegBlank : ~SegBlank;

  typedef enum logic [0:0] {StIdle, StConv} conv_state_e;

  conv_state_e state_q, state_d;
  logic [7*NumFields-1:0]       shadow_q, shadow_d;
  logic [FldW-1:0]              fld_q, fld_d;
  logic [NUM_DIGITS-1:0][3:0]   pend_q, pend_d;
  logic [NUM_DIGITS-1:0][3:0]   disp_q, disp_d;
  logic [DivW-1:0]              div_q, div_d;
  logic [IdxW-1:0]              idx_q, idx_d;
  logic [FrmW-1:0]              frame_q, frame_d;
  logic                         phase_q, phase_d;
  logic [NUM_DIGITS-1:0]        an_q, an_d;
  logic [6:0]                   seg_q, seg_d;

  logic [6:0] cur_val;
  logic [3:0] tens, ones;
  logic [3:0] cur_code;
  logic       cur_blink;
  logic [6:0] seg_al;
  logic [NUM_DIGITS-1:0] an_al;

  function automatic logic [6:0] decode_seg(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      4'd10:   s = 7'b0111111;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  // Field currently being converted, split into tens/ones.
  always_comb begin
    cur_val = '0;
    for (int k = 0; k < NumFields; k++) begin
      if (fld_q == FldW'(k)) cur_val = shadow_q[7*k +: 7];
    end
    if (cur_val > 7'd99) begin
      tens = CodeDash;
      ones = CodeDash;
    end else begin
      tens = 4'(cur_val / 7'd10);
      ones = 4'(cur_val % 7'd10);
    end
  end

  // Conversion FSM.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    fld_d    = fld_q;
    pend_d   = pend_q;
    disp_d   = disp_q;
    unique case (state_q)
      StIdle: begin
        if (bus.load) begin
          shadow_d = bus.field_bin;
          fld_d    = '0;
          state_d  = StConv;
        end
      end
      StConv: begin
        for (int k = 0; k < NumFields; k++) begin
          if (fld_q == FldW'(k)) begin
            pend_d[2*k]   = ones;
            pend_d[2*k+1] = tens;
          end
        end
        if (fld_q == FldLast) begin
          // Last field lands in the same cycle the whole frame is committed.
          disp_d  = pend_d;
          state_d = StIdle;
        end else begin
          fld_d = fld_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Scan divider, digit index, frame counter and blink phase.
  always_comb begin
    div_d   = div_q + 1'b1;
    idx_d   = idx_q;
    frame_d = frame_q;
    phase_d = phase_q;
    if (div_q == DivMax) begin
      div_d = '0;
      if (idx_q == IdxMax) begin
        idx_d = '0;
        if (frame_q == FrmMax) begin
          frame_d = '0;
          phase_d = ~phase_q;
        end else begin
          frame_d = frame_q + 1'b1;
        end
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Output selection for the current digit, registered one cycle later.
  always_comb begin
    cur_code  = CodeBlank;
    cur_blink = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx_q == IdxW'(d)) begin
        cur_code  = disp_q[d];
        cur_blink = bus.blink_mask[d/2];
      end
    end

    if (!bus.enable) begin
      seg_al = SegBlank;
    end else if (bus.err) begin
      seg_al = SegErr;
    end else if (phase_q && cur_blink) begin
      seg_al = SegBlank;
    end else begin
      seg_al = decode_seg(cur_code);
    end

    for (int d = 0; d < NUM_DIGITS; d++) begin
      an_al[d] = !(bus.enable && (idx_q == IdxW'(d)));
    end

    seg_d = ACTIVE_LOW ? seg_al : ~seg_al;
    an_d  = ACTIVE_LOW ? an_al : ~an_al;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      fld_q    <= '0;
      pend_q   <= {NUM_DIGITS{CodeBlank}};
      disp_q   <= {NUM_DIGITS{CodeBlank}};
      div_q    <= '0;
      idx_q    <= '0;
      frame_q  <= '0;
      phase_q  <= 1'b0;
      an_q     <= AnIdle;
      seg_q    <= SegIdle;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      fld_q    <= fld_d;
      pend_q   <= pend_d;
      disp_q   <= disp_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      phase_q  <= phase_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign bus.busy = (state_q == StConv);
  assign bus.an   = an_q;
  assign bus.seg  = seg_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
module tb_seg_scan_controller;
  localparam int unsigned ND = 8;
  localparam int unsigned NF = ND / 2;
  localparam int unsigned SD = 4;
  localparam int unsigned BD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_controller_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_controller #(
    .NUM_DIGITS(ND),
    .SCAN_DIV  (SD),
    .BLINK_DIV (BD),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: cycles since reset, remaining busy cycles, displayed digits
  // (-1 blank, 10 dash, else decimal value) and the captured fields.
  int mdl_count = 0;
  int mdl_busy_left = 0;
  int mdl_disp[ND];
  int mdl_shadow[NF];
  logic [6:0] last_seg[ND];
  int vis_cnt[ND];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      10:      return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int d, input int count);
    int phase;
    phase = ((count / (SD * ND)) / BD) % 2;
    if (!bus.enable) return 7'b1111111;
    if (bus.err) return 7'b0000110;
    if (phase == 1 && bus.blink_mask[d/2]) return 7'b1111111;
    return seg_of(mdl_disp[d]);
  endfunction

  task automatic step();
    logic [6:0]      e_seg;
    logic [ND-1:0]   e_an;
    logic [ND-1:0]   one_hot;
    logic [7*NF-1:0] fb_s;
    logic            load_s;
    logic            rst_s;
    int              idx;
    int              v;
    rst_s  = rst;
    load_s = bus.load;
    fb_s   = bus.field_bin;
    if (rst_s) begin
      e_seg = 7'b1111111;
      e_an  = '1;
    end else begin
      idx = (mdl_count / SD) % ND;
      one_hot = '0;
      one_hot[idx] = 1'b1;
      e_an  = bus.enable ? ~one_hot : '1;
      e_seg = exp_seg(idx, mdl_count);
    end
    @(posedge clk);
    if (rst_s) begin
      mdl_count = 0;
      mdl_busy_left = 0;
      for (int d = 0; d < ND; d++) mdl_disp[d] = -1;
    end else begin
      mdl_count++;
      if (mdl_busy_left > 0) begin
        mdl_busy_left--;
        if (mdl_busy_left == 0) begin
          for (int k = 0; k < NF; k++) begin
            v = mdl_shadow[k];
            if (v > 99) begin
              mdl_disp[2*k]   = 10;
              mdl_disp[2*k+1] = 10;
            end else begin
              mdl_disp[2*k]   = v % 10;
              mdl_disp[2*k+1] = v / 10;
            end
          end
        end
      end else if (load_s) begin
        for (int k = 0; k < NF; k++) mdl_shadow[k] = int'(fb_s[7*k +: 7]);
        mdl_busy_left = NF;
      end
    end
    #1;
    check("an", 32'(bus.an), 32'(e_an));
    check("seg", 32'(bus.seg), 32'(e_seg));
    check("busy", 32'(bus.busy), 32'(mdl_busy_left > 0));
    for (int d = 0; d < ND; d++) begin
      if (bus.an == ~(ND'(1) << d)) begin
        last_seg[d] = bus.seg;
        if (bus.seg != 7'b1111111) vis_cnt[d]++;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_fields(input int f0, input int f1, input int f2, input int f3);
    bus.field_bin = {7'(f3), 7'(f2), 7'(f1), 7'(f0)};
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      mdl_disp[d] = -1;
      last_seg[d] = 7'b1111111;
      vis_cnt[d]  = 0;
    end
    for (int k = 0; k < NF; k++) mdl_shadow[k] = 0;
    bus.field_bin  = '0;
    bus.load       = 1'b0;
    bus.blink_mask = '0;
    bus.err        = 1'b0;
    bus.enable     = 1'b1;

    // Reset state.
    rst = 1'b1;
    run(3);
    check("rst_an", 32'(bus.an), 32'hff);
    check("rst_seg", 32'(bus.seg), 32'h7f);
    check("rst_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;

    // Blank display before any conversion.
    run(33);
    check("pre_conv_d3_blank", 32'(last_seg[3]), 32'h7f);

    // Basic conversion, busy exactly NF cycles.
    load_fields(59, 7, 23, 31);
    for (int i = 0; i < NF; i++) begin
      check("busy_high", 32'(bus.busy), 32'h1);
      step();
    end
    check("busy_fell", 32'(bus.busy), 32'h0);
    run(34);
    check("d0_9", 32'(last_seg[0]), 32'(7'b0010000));
    check("d1_5", 32'(last_seg[1]), 32'(7'b0010010));
    check("d2_7", 32'(last_seg[2]), 32'(7'b1111000));
    check("d3_0", 32'(last_seg[3]), 32'(7'b1000000));

    // Load while busy is ignored.
    load_fields(12, 34, 56, 78);
    load_fields(88, 88, 88, 88);
    run(40);
    check("ign_d0", 32'(last_seg[0]), 32'(7'b0100100));
    check("ign_d7", 32'(last_seg[7]), 32'(7'b1111000));

    // Value above 99 shows dashes.
    load_fields(1, 2, 120, 99);
    run(40);
    check("dash_d4", 32'(last_seg[4]), 32'(7'b0111111));
    check("dash_d5", 32'(last_seg[5]), 32'(7'b0111111));
    check("d6_9", 32'(last_seg[6]), 32'(7'b0010000));

    // Blink field 0: half of two full blink periods visible, other digits always.
    bus.blink_mask = 4'b0001;
    for (int d = 0; d < ND; d++) vis_cnt[d] = 0;
    run(2 * 2 * BD * SD * ND);
    check("blink_d0_vis", 32'(vis_cnt[0]), 32'(2 * BD * SD));
    check("blink_d1_vis", 32'(vis_cnt[1]), 32'(2 * BD * SD));
    check("blink_d2_vis", 32'(vis_cnt[2]), 32'(4 * BD * SD));
    bus.blink_mask = '0;

    // Error and enable.
    bus.err = 1'b1;
    run(34);
    check("err_d0", 32'(last_seg[0]), 32'(7'b0000110));
    check("err_d7", 32'(last_seg[7]), 32'(7'b0000110));
    bus.enable = 1'b0;
    run(3);
    check("dis_an", 32'(bus.an), 32'hff);
    check("dis_seg", 32'(bus.seg), 32'h7f);
    bus.err = 1'b0;
    bus.enable = 1'b1;
    run(5);

    // Reset mid-conversion.
    load_fields(11, 22, 33, 44);
    run(2);
    rst = 1'b1;
    step();
    check("abort_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    step();
    check("restart_an", 32'(bus.an), 32'hfe);
    check("restart_seg", 32'(bus.seg), 32'h7f);
    run(40);

    // Randomized traffic against the model.
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < NF; k++)
        bus.field_bin[7*k +: 7] = 7'($urandom_range(0, 127));
      bus.blink_mask = 4'($urandom_range(0, 15));
      bus.err        = ($urandom_range(0, 7) == 0);
      bus.enable     = ($urandom_range(0, 7) != 0);
      for (int n = $urandom_range(5, 60); n > 0; n--) begin
        bus.load = ($urandom_range(0, 5) == 0);
        rst      = ($urandom_range(0, 99) == 0);
        step();
      end
      bus.load = 1'b0;
      rst = 1'b0;
    end
    run(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_controller.md
SEG_SCAN_CONTROLLER -- requirements
Module: seg_scan_controller

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, meaning the digit count (even, 2..8); NUM_FIELDS = NUM_DIGITS/2 two-digit fields.
REQ-002 SHALL have parameter SCAN_DIV, default 1000, meaning clk cycles each digit is driven (>=2).
REQ-003 SHALL have parameter BLINK_DIV, default 64, meaning full scan frames per blink half-period (>=1).
REQ-004 SHALL have parameter ACTIVE_LOW, default 1, meaning segment/anode polarity (1 = low lights the segment/digit).
REQ-005 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port field_bin  input  7*NUM_FIELDS  packed binary field values; field k = bits [7k+6:7k], field 0 = rightmost digits.
REQ-008 SHALL have port load  input  1  single-cycle request to capture field_bin.
REQ-009 SHALL have port blink_mask  input  NUM_FIELDS  bit k=1 blinks field k.
REQ-010 SHALL have port err  input  1  level; forces 'E' on all digits.
REQ-011 SHALL have port enable  input  1  level; 0 blanks all digits.
REQ-012 SHALL have port busy  output  1  conversion in progress; load ignored.
REQ-013 SHALL have port an  output  NUM_DIGITS  one-hot digit select (polarity per ACTIVE_LOW).
REQ-014 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}; all outputs registered.

Function
REQ-015 SHALL, when load=1 and busy=0, capture field_bin into a shadow register and assert busy the next cycle; load while busy=1 SHALL be ignored.
REQ-016 SHALL convert one field per cycle (field 0 first) into tens/ones digits; busy SHALL stay high exactly NUM_FIELDS cycles.
REQ-017 SHALL update all displayed digits atomically on the cycle busy falls; no partial frame is ever shown.
REQ-018 SHALL display a field value >99 as two dashes (segment g only).
REQ-019 SHALL use a divider counting 0..SCAN_DIV-1; on wrap, digit index advances 0..NUM_DIGITS-1 and wraps to 0.
REQ-020 SHALL count a frame on each digit-index wrap from NUM_DIGITS-1 to 0; after BLINK_DIV frames the blink phase toggles and the frame counter clears.
REQ-021 SHALL drive an/seg for the current digit index with one cycle latency from the index change.
REQ-022 SHALL set segment priority: enable=0 -> blank; else err=1 -> 'E'; else blink phase=1 and blink_mask bit of the digit's field=1 -> blank; else digit value.
REQ-023 SHALL, when enable=0, also deassert all anodes; scan counters keep running.
REQ-024 SHALL use active-low codes (ACTIVE_LOW=1): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, E=0000110, dash=0111111, blank=1111111; ACTIVE_LOW=0 inverts seg and an.
REQ-025 SHALL treat err, blink_mask, enable as live levels sampled each cycle, not latched by load.

Reset
REQ-026 SHALL, with rst=1, clear divider, digit index, frame counter, blink phase, busy and shadow registers; an all inactive, seg blank.
REQ-027 SHALL hold displayed digits blank after reset until the first conversion completes.
REQ-028 SHALL abort an in-progress conversion on rst; displayed digits revert to blank.
REQ-029 SHALL resume scanning at digit 0 on the first cycle after rst deasserts.

Verification
REQ-030 SHALL verify: NUM_DIGITS=8, SCAN_DIV=4, load fields {0:59,1:7,2:23,3:31} -> busy 4 cycles; digit0 seg=0010000, digit1 0010010, digit2 1111000, digit3 1000000.
REQ-031 SHALL verify: second load asserted while busy -> ignored; displayed values unchanged after busy falls.
REQ-032 SHALL verify: field value 120 -> both digits of that field show 0111111.
REQ-033 SHALL verify: BLINK_DIV=2, blink_mask=0001 -> digits 0-1 blank for 2 frames, visible 2 frames; other digits always visible.
REQ-034 SHALL verify: err=1 with enable=1 -> all digits 0000110; enable=0 -> an all inactive, seg 1111111.
REQ-035 SHALL verify: rst pulsed mid-conversion -> busy=0 next cycle, display blank, scan restarts at digit 0.
